io_output_bank: RTL and testbench

- Parametrised successor to the fixed three-port memory-mapped output register block on the single-cycle CPU IO bus.
- Provides N_PORTS output registers of DATA_W bits with atomic set/clear/toggle write aliases and registered readback.
- Adds per-port write strobes and a one-shot pulse timer register.
- Sits beside the IO input block; driven by the CPU's addr/datain and write/read IO enables.

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_pulse_timer.sv | 28 ++
 rtl/io_output_bank.sv | 111 +++++++++++
 tb/tb_io_output_bank.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants for the CPU IO bus blocks: write modes, default base
// word index and the address field positions.
package io_pkg;

  // Write-mode encodings carried in addr[9:8]
  localparam logic [1:0] MODE_WR  = 2'b00;
  localparam logic [1:0] MODE_SET = 2'b01;
  localparam logic [1:0] MODE_CLR = 2'b10;
  localparam logic [1:0] MODE_TGL = 2'b11;

  // Word index of the first output port
  localparam int DEFAULT_BASE_IDX = 32;

  // Address field positions
  localparam int IDX_LSB  = 2;
  localparam int IDX_MSB  = 7;
  localparam int MODE_LSB = 8;
  localparam int MODE_MSB = 9;

endpackage

// File: rtl/io_pulse_timer.sv
// One-shot pulse timer: a loadable down-counter that saturates at zero.
// pulse_out is high while the count is non-zero, so loading L gives L cycles
// of pulse starting the cycle after the load edge. Loading 0 cancels.
module io_pulse_timer import io_pkg::*; #(
  parameter int PULSE_W = 16
) (
  input  logic               io_clk,
  input  logic               clrn,
  input  logic               load,
  input  logic [PULSE_W-1:0] load_val,
  output logic [PULSE_W-1:0] count,
  output logic               pulse_out
);

  // Reset beats load, load beats decrement (a reload skips that cycle's decrement)
  always_ff @(posedge io_clk) begin
    if (!clrn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign pulse_out = (count != '0);

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output register bank on the single-cycle CPU IO bus.
// N_PORTS registers with write/set/clear/toggle aliases, per-port write
// strobes, a one-shot pulse timer and registered readback.
//
// Read handshake: read_io_enable is sampled at the rising edge; in the
// following cycle dataout carries the read data and read_valid is high for
// exactly that one cycle. There is no backpressure; dataout holds its last
// value (and read_valid is low) in cycles without a read.
module io_output_bank import io_pkg::*; #(
  parameter int N_PORTS  = 3,
  parameter int DATA_W   = 32,
  parameter int BASE_IDX = DEFAULT_BASE_IDX,
  parameter int PULSE_W  = 16
) (
  input  logic                      io_clk,
  input  logic                      clrn,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         datain,
  input  logic                      write_io_enable,
  input  logic                      read_io_enable,
  output logic [N_PORTS*DATA_W-1:0] out_port,
  output logic [DATA_W-1:0]         dataout,
  output logic                      read_valid,
  output logic [N_PORTS-1:0]        port_wr_strobe,
  output logic                      pulse_out
);

  localparam logic [5:0] PULSE_IDX = 6'(BASE_IDX + N_PORTS);

  if (N_PORTS < 1 || N_PORTS > 16 || BASE_IDX + N_PORTS > 63 || PULSE_W > DATA_W)
  begin : g_param_error
    $error("io_output_bank: illegal parameter combination");
  end

  logic [5:0]         word_idx;
  logic [1:0]         mode;
  logic               unused_addr_bits;
  logic [DATA_W-1:0]  port_val [N_PORTS];
  logic [PULSE_W-1:0] pulse_count;
  logic               pulse_load;
  logic [DATA_W-1:0]  rd_data;

  assign word_idx         = addr[IDX_MSB:IDX_LSB];
  assign mode             = addr[MODE_MSB:MODE_LSB];
  assign unused_addr_bits = ^{addr[31:10], addr[1:0]};

  // Port registers, one per generate iteration
  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    localparam logic [5:0] MY_IDX = 6'(BASE_IDX + i);
    logic              hit;
    logic [DATA_W-1:0] q;
    logic              stb_q;

    assign hit = write_io_enable && (word_idx == MY_IDX);

    // Apply the addressed write mode and raise the strobe for one cycle
    always_ff @(posedge io_clk) begin
      if (!clrn) begin
        q     <= '0;
        stb_q <= 1'b0;
      end else begin
        stb_q <= hit;
        if (hit) begin
          case (mode)
            MODE_WR:  q <= datain;
            MODE_SET: q <= q | datain;
            MODE_CLR: q <= q & ~datain;
            MODE_TGL: q <= q ^ datain;
          endcase
        end
      end
    end

    assign port_val[i]                      = q;
    assign out_port[i*DATA_W +: DATA_W]     = q;
    assign port_wr_strobe[i]                = stb_q;
  end

  // Only a plain write reaches the pulse register; alias modes are dropped
  assign pulse_load = write_io_enable && (word_idx == PULSE_IDX) && (mode == MODE_WR);

  io_pulse_timer #(.PULSE_W(PULSE_W)) u_pulse (
    .io_clk    (io_clk),
    .clrn      (clrn),
    .load      (pulse_load),
    .load_val  (datain[PULSE_W-1:0]),
    .count     (pulse_count),
    .pulse_out (pulse_out)
  );

  // Readback mux over current (pre-write) register state; unmapped reads 0
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (word_idx == 6'(BASE_IDX + i)) rd_data = port_val[i];
    end
    if (word_idx == PULSE_IDX) rd_data[PULSE_W-1:0] = pulse_count;
  end

  // Register the read data and its one-cycle valid flag
  always_ff @(posedge io_clk) begin
    if (!clrn) begin
      dataout    <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_io_enable;
      if (read_io_enable) dataout <= rd_data;
    end
  end

endmodule

// File: tb/tb_io_output_bank.sv
// Directed testbench for io_output_bank: default instance (3 x 32-bit, base 32)
// and a wide instance (8 x 16-bit, base 16).
module tb_io_output_bank;

  logic        io_clk;
  logic        clrn;

  logic [31:0] a_addr;
  logic [31:0] a_datain;
  logic        a_wr;
  logic        a_rd;
  logic [95:0] a_out_port;
  logic [31:0] a_dataout;
  logic        a_rv;
  logic [2:0]  a_stb;
  logic        a_pulse;

  logic [31:0]  b_addr;
  logic [15:0]  b_datain;
  logic         b_wr;
  logic         b_rd;
  logic [127:0] b_out_port;
  logic [15:0]  b_dataout;
  logic         b_rv;
  logic [7:0]   b_stb;
  logic         b_pulse;

  int n_checks;
  int n_fail;

  io_output_bank dut_a (
    .io_clk          (io_clk),
    .clrn            (clrn),
    .addr            (a_addr),
    .datain          (a_datain),
    .write_io_enable (a_wr),
    .read_io_enable  (a_rd),
    .out_port        (a_out_port),
    .dataout         (a_dataout),
    .read_valid      (a_rv),
    .port_wr_strobe  (a_stb),
    .pulse_out       (a_pulse)
  );

  io_output_bank #(.N_PORTS(8), .DATA_W(16), .BASE_IDX(16), .PULSE_W(16)) dut_b (
    .io_clk          (io_clk),
    .clrn            (clrn),
    .addr            (b_addr),
    .datain          (b_datain),
    .write_io_enable (b_wr),
    .read_io_enable  (b_rd),
    .out_port        (b_out_port),
    .dataout         (b_dataout),
    .read_valid      (b_rv),
    .port_wr_strobe  (b_stb),
    .pulse_out       (b_pulse)
  );

  // Clock
  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic cyc();
    @(posedge io_clk);
    #1;
  endtask

  task automatic do_write_a(input logic [31:0] ad, input logic [31:0] d);
    a_addr = ad; a_datain = d; a_wr = 1'b1;
    cyc();
    a_wr = 1'b0;
  endtask

  task automatic do_read_a(input logic [31:0] ad);
    a_addr = ad; a_rd = 1'b1;
    cyc();
    a_rd = 1'b0;
  endtask

  task automatic do_write_b(input logic [31:0] ad, input logic [15:0] d);
    b_addr = ad; b_datain = d; b_wr = 1'b1;
    cyc();
    b_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] ra [4];
    ra = '{32'h080, 32'h084, 32'h088, 32'h08C};
    clrn = 1'b0;
    cyc(); cyc();
    clrn = 1'b1;
    n_checks++; if (a_out_port !== 96'h0) begin n_fail++; $display("FAIL reset_out_port got %h exp 0", a_out_port); end
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b exp 0", a_pulse); end
    n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL reset_strobe got %b exp 000", a_stb); end
    n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_read_valid got %b exp 0", a_rv); end
    n_checks++; if (b_out_port !== 128'h0) begin n_fail++; $display("FAIL reset_b_out_port got %h exp 0", b_out_port); end
    for (int k = 0; k < 4; k++) begin
      do_read_a(ra[k]);
      n_checks++; if (a_dataout !== 32'h0) begin n_fail++; $display("FAIL reset_read[%0d] dataout got %h exp 0", k, a_dataout); end
      n_checks++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL reset_read[%0d] read_valid got %b exp 1", k, a_rv); end
    end
    cyc();
    n_checks++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL read_valid_drop got %b exp 0", a_rv); end
  endtask

  task automatic test_modes();
    logic [31:0] ad [5];
    logic [31:0] d  [5];
    logic [31:0] ex [5];
    ad = '{32'h084, 32'h184, 32'h284, 32'h384, 32'h384};
    d  = '{32'hF0,  32'h0F,  32'h3C,  32'hFF,  32'h00};
    ex = '{32'hF0,  32'hFF,  32'hC3,  32'h3C,  32'h3C};
    for (int k = 0; k < 5; k++) begin
      do_write_a(ad[k], d[k]);
      n_checks++; if (a_out_port[63:32] !== ex[k]) begin n_fail++; $display("FAIL mode[%0d] port1 got %h exp %h", k, a_out_port[63:32], ex[k]); end
      n_checks++; if (a_stb !== 3'b010) begin n_fail++; $display("FAIL mode[%0d] strobe got %b exp 010", k, a_stb); end
      n_checks++; if ({a_out_port[95:64], a_out_port[31:0]} !== 64'h0) begin n_fail++; $display("FAIL mode[%0d] other_ports got %h exp 0", k, {a_out_port[95:64], a_out_port[31:0]}); end
      cyc();
      n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL mode[%0d] strobe_drop got %b exp 000", k, a_stb); end
    end
  endtask

  task automatic test_pulse();
    // Plain pulse of 5
    do_write_a(32'h08C, 32'd5);
    n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL pulse_no_port_strobe got %b exp 000", a_stb); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (a_pulse !== 1'b1) begin n_fail++; $display("FAIL pulse5 cycle %0d got %b exp 1", k, a_pulse); end
      cyc();
    end
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse5_end got %b exp 0", a_pulse); end
    // Alias mode to pulse register is ignored
    do_write_a(32'h18C, 32'd7);
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_alias_ignored got %b exp 0", a_pulse); end
    n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL pulse_alias_strobe got %b exp 000", a_stb); end
    // Reload 3 at cycle 2
    do_write_a(32'h08C, 32'd5);
    cyc(); cyc();
    do_write_a(32'h08C, 32'd3);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (a_pulse !== 1'b1) begin n_fail++; $display("FAIL pulse_reload cycle %0d got %b exp 1", k, a_pulse); end
      cyc();
    end
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_reload_end got %b exp 0", a_pulse); end
    // Readback of remaining count, then cancel with 0
    do_write_a(32'h08C, 32'd8);
    do_read_a(32'h08C);
    n_checks++; if (a_dataout !== 32'd8) begin n_fail++; $display("FAIL pulse_read got %h exp 8", a_dataout); end
    n_checks++; if (a_pulse !== 1'b1) begin n_fail++; $display("FAIL pulse_active got %b exp 1", a_pulse); end
    do_write_a(32'h08C, 32'd0);
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_cancel got %b exp 0", a_pulse); end
  endtask

  task automatic test_collision();
    do_write_a(32'h080, 32'h11);
    a_addr = 32'h080; a_datain = 32'h22; a_wr = 1'b1; a_rd = 1'b1;
    cyc();
    a_wr = 1'b0; a_rd = 1'b0;
    n_checks++; if (a_dataout !== 32'h11) begin n_fail++; $display("FAIL collision_read got %h exp 11", a_dataout); end
    n_checks++; if (a_out_port[31:0] !== 32'h22) begin n_fail++; $display("FAIL collision_port0 got %h exp 22", a_out_port[31:0]); end
    n_checks++; if (a_stb !== 3'b001) begin n_fail++; $display("FAIL collision_strobe got %b exp 001", a_stb); end
  endtask

  task automatic test_unmapped();
    do_write_a(32'h0FC, 32'hDEAD);
    n_checks++; if (a_out_port !== {32'h0, 32'h3C, 32'h22}) begin n_fail++; $display("FAIL unmapped_write got %h exp %h", a_out_port, {32'h0, 32'h3C, 32'h22}); end
    n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL unmapped_strobe got %b exp 000", a_stb); end
    do_read_a(32'h0FC);
    n_checks++; if (a_dataout !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", a_dataout); end
    // Upper address bits are ignored: this is port 2, mode 00
    do_write_a(32'h1000_0088, 32'h55);
    n_checks++; if (a_out_port[95:64] !== 32'h55) begin n_fail++; $display("FAIL high_addr_bits port2 got %h exp 55", a_out_port[95:64]); end
    n_checks++; if (a_stb !== 3'b100) begin n_fail++; $display("FAIL high_addr_bits strobe got %b exp 100", a_stb); end
  endtask

  task automatic test_reset_mid();
    do_write_a(32'h08C, 32'd100);
    repeat (9) cyc();
    n_checks++; if (a_pulse !== 1'b1) begin n_fail++; $display("FAIL long_pulse_active got %b exp 1", a_pulse); end
    // Reset wins over a concurrent write
    clrn = 1'b0;
    a_addr = 32'h084; a_datain = 32'hAA; a_wr = 1'b1;
    cyc();
    clrn = 1'b1; a_wr = 1'b0;
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pulse got %b exp 0", a_pulse); end
    n_checks++; if (a_out_port !== 96'h0) begin n_fail++; $display("FAIL reset_mid_ports got %h exp 0", a_out_port); end
    n_checks++; if (a_stb !== 3'b000) begin n_fail++; $display("FAIL reset_mid_strobe got %b exp 000", a_stb); end
    n_checks++; if (a_dataout !== 32'h0) begin n_fail++; $display("FAIL reset_mid_dataout got %h exp 0", a_dataout); end
    cyc();
    n_checks++; if (a_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pulse_after got %b exp 0", a_pulse); end
  endtask

  task automatic test_param();
    logic [31:0] ad [4];
    logic [15:0] d  [4];
    logic [15:0] ex [4];
    ad = '{32'h05C, 32'h15C, 32'h25C, 32'h35C};
    d  = '{16'hF0F0, 16'h000F, 16'h00F0, 16'hFFFF};
    ex = '{16'hF0F0, 16'hF0FF, 16'hF00F, 16'h0FF0};
    for (int k = 0; k < 4; k++) begin
      do_write_b(ad[k], d[k]);
      n_checks++; if (b_out_port[127:112] !== ex[k]) begin n_fail++; $display("FAIL b_mode[%0d] port7 got %h exp %h", k, b_out_port[127:112], ex[k]); end
      n_checks++; if (b_stb !== 8'h80) begin n_fail++; $display("FAIL b_mode[%0d] strobe got %h exp 80", k, b_stb); end
    end
    n_checks++; if (b_out_port[111:0] !== 112'h0) begin n_fail++; $display("FAIL b_other_ports got %h exp 0", b_out_port[111:0]); end
    // Below the base index is unmapped
    do_write_b(32'h03C, 16'h1234);
    n_checks++; if (b_stb !== 8'h00) begin n_fail++; $display("FAIL b_unmapped_strobe got %h exp 00", b_stb); end
    n_checks++; if (b_out_port[127:112] !== 16'h0FF0) begin n_fail++; $display("FAIL b_unmapped_port7 got %h exp 0ff0", b_out_port[127:112]); end
    // Pulse register sits right after port 7
    do_write_b(32'h060, 16'd3);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (b_pulse !== 1'b1) begin n_fail++; $display("FAIL b_pulse cycle %0d got %b exp 1", k, b_pulse); end
      cyc();
    end
    n_checks++; if (b_pulse !== 1'b0) begin n_fail++; $display("FAIL b_pulse_end got %b exp 0", b_pulse); end
    b_addr = 32'h05C; b_rd = 1'b1;
    cyc();
    b_rd = 1'b0;
    n_checks++; if (b_dataout !== 16'h0FF0) begin n_fail++; $display("FAIL b_read_port7 got %h exp 0ff0", b_dataout); end
    n_checks++; if (b_rv !== 1'b1) begin n_fail++; $display("FAIL b_read_valid got %b exp 1", b_rv); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clrn = 1'b0;
    a_addr = '0; a_datain = '0; a_wr = 1'b0; a_rd = 1'b0;
    b_addr = '0; b_datain = '0; b_wr = 1'b0; b_rd = 1'b0;
    #1;
    test_reset();
    test_modes();
    test_pulse();
    test_collision();
    test_unmapped();
    test_reset_mid();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
